// File: rtl/pred_regfile_sb_pkg.sv
// Shared constants and FSM state type for the predicated register file.
// Defaults here seed the top-level parameters of pred_regfile_sb.
package pred_regfile_sb_pkg;
  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int NUM_RD_DEF   = 3;
  localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);
  localparam int PC_IDX_DEF   = 30;
  localparam int ZERO_IDX     = 0;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/pred_regfile_sb_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set on issue, cleared on write-back.
// Set wins over clear at the same address; lookups read the registered bits only.
module regfile_scoreboard
  import pred_regfile_sb_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int PC_IDX   = PC_IDX_DEF,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy
);
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (reset) begin
      busy_d = '0;
    end else begin
      if (clr_en) busy_d[clr_addr] = 1'b0;
      if (set_en) busy_d[set_addr] = 1'b1;
    end
    // r0 and the PC mirror never have an outstanding producer
    busy_d[ZERO_IDX] = 1'b0;
    busy_d[PC_IDX]   = 1'b0;
  end

  always_ff @(posedge clk) begin
    busy_q <= busy_d;
  end

  genvar k;
  for (k = 0; k < NUM_RD; k++) begin : g_lookup
    assign rd_busy[k] = busy_q[rd_addr[k*ADDR_W +: ADDR_W]];
  end
endmodule

// File: rtl/pred_regfile_sb.sv
// Predicated register file with PC mirror, write-through bypass, scoreboard and
// an init sequencer that zeroes one entry per cycle after reset.
module pred_regfile_sb
  import pred_regfile_sb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int PC_IDX   = PC_IDX_DEF,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic [DATA_W-1:0]        pc_next,
  output logic [DATA_W-1:0]        pc,
  output logic                     ready,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [ADDR_W-1:0]        wr_pred_idx,
  input  logic                     wr_pred_res,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr
);
  localparam logic [ADDR_W-1:0] PC_A   = ADDR_W'(PC_IDX);
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(NUM_REGS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];

  logic                wr_tgt_ok;
  logic                commit;
  logic                iss_ok;
  logic [NUM_RD-1:0]   sb_busy;

  assign ready     = (state_q == ST_RUN);
  assign pc        = pc_q;
  assign wr_tgt_ok = wr_en && (wr_addr != ZERO_A) && (wr_addr != PC_A);
  assign commit    = ready && wr_tgt_ok && ((wr_pred_idx == ZERO_A) || wr_pred_res);
  assign iss_ok    = ready && iss_en && (iss_addr != ZERO_A) && (iss_addr != PC_A);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    regs_d  = regs_q;
    if (reset) begin
      state_d = ST_INIT;
      cnt_d   = '0;
      pc_d    = '0;
    end else if (state_q == ST_INIT) begin
      regs_d[cnt_q] = '0;
      cnt_d         = cnt_q + ADDR_W'(1);
      if (cnt_q == LAST_A) state_d = ST_RUN;
    end else begin
      if (commit) regs_d[wr_addr] = wr_data;
      if (!stall) begin
        pc_d           = pc_next;
        regs_d[PC_IDX] = pc_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    pc_q    <= pc_d;
    regs_q  <= regs_d;
  end

  genvar k;
  for (k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = rd_addr[k*ADDR_W +: ADDR_W];
    // Before init completes the raw array is exposed, with no special cases
    assign rd_data[k*DATA_W +: DATA_W] =
      !ready                      ? regs_q[ra] :
      (ra == ZERO_A)              ? '0         :
      (ra == PC_A)                ? pc_q       :
      (commit && ra == wr_addr)   ? wr_data    :
                                    regs_q[ra];
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .PC_IDX   (PC_IDX)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (iss_ok),
    .set_addr (iss_addr),
    .clr_en   (ready && wr_tgt_ok),
    .clr_addr (wr_addr),
    .rd_addr  (rd_addr),
    .rd_busy  (sb_busy)
  );

  assign rd_busy = ready ? sb_busy : '0;
endmodule

// File: tb/tb_pred_regfile_sb.sv
// Directed bench for pred_regfile_sb: a per-cycle behavioural model compared on
// every falling edge, plus hand-computed expectations at key points.
module tb_pred_regfile_sb;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int NRD = 3;
  localparam int PCI = 30;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              stall = 1'b0;
  logic [DW-1:0]     pc_next = '0;
  logic [DW-1:0]     pc;
  logic              ready;
  logic [NRD*AW-1:0] rd_addr = '0;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [DW-1:0]     wr_data = '0;
  logic [AW-1:0]     wr_pred_idx = '0;
  logic              wr_pred_res = 1'b0;
  logic              iss_en = 1'b0;
  logic [AW-1:0]     iss_addr = '0;

  int n_tests = 0;
  int n_fail = 0;

  pred_regfile_sb dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_next(pc_next), .pc(pc),
    .ready(ready), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_pred_idx(wr_pred_idx), .wr_pred_res(wr_pred_res),
    .iss_en(iss_en), .iss_addr(iss_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_regs [NR];
  bit            m_busy [NR];
  logic [DW-1:0] m_pc = '0;
  bit            m_ready = 1'b0;
  bit            m_valid = 1'b0;
  int            m_init_idx = 0;

  function automatic bit m_commit();
    return m_ready && wr_en && (wr_pred_idx == 0 || wr_pred_res) &&
           wr_addr != 0 && wr_addr != PCI;
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (a == PCI) return m_pc;
    if (m_commit() && a == wr_addr) return wr_data;
    return m_regs[a];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b1;
      m_ready = 1'b0;
      m_pc = '0;
      m_init_idx = 0;
      for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
    end else if (m_valid && !m_ready) begin
      m_regs[m_init_idx] = '0;
      m_init_idx++;
      if (m_init_idx == NR) m_ready = 1'b1;
    end else if (m_ready) begin
      if (m_commit()) m_regs[wr_addr] = wr_data;
      if (!stall) begin
        m_pc = pc_next;
        m_regs[PCI] = pc_next;
      end
      if (wr_en && wr_addr != 0 && wr_addr != PCI) m_busy[wr_addr] = 1'b0;
      if (iss_en && iss_addr != 0 && iss_addr != PCI) m_busy[iss_addr] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("ready", ready, m_ready);
      check("pc", pc, m_pc);
      for (int k = 0; k < NRD; k++) begin
        logic [AW-1:0] a;
        a = rd_addr[k*AW +: AW];
        check("rd_busy", rd_busy[k], m_ready ? m_busy[a] : 1'b0);
        if (m_ready) check("rd_data", rd_data[k*DW +: DW], m_read(a));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (ready) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic clr_wr();
    wr_en = 1'b0; wr_pred_idx = '0; wr_pred_res = 1'b0; iss_en = 1'b0;
  endtask

  int n_cyc;

  initial begin
    // reset 1 cycle, then count init cycles
    rd_addr = {5'd3, 5'd2, 5'd1};
    tick();
    reset = 1'b0;
    wait_ready(n_cyc);
    check("init_cycles", n_cyc, 32);
    #2;
    check("init_rd0", rd_data[31:0], 32'h0);
    check("init_pc", pc, 32'h0);

    // same-cycle bypass of r5
    tick();
    rd_addr = {5'd0, 5'd0, 5'd5};
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234;
    #2 check("bypass_r5", rd_data[31:0], 32'h1234);
    tick();
    clr_wr();
    #2 check("held_r5", rd_data[31:0], 32'h1234);

    // squashed write still retires its producer
    tick();
    rd_addr = {5'd0, 5'd0, 5'd7};
    iss_en = 1'b1; iss_addr = 5'd7;
    tick();
    clr_wr();
    #2 check("busy_r7_set", rd_busy[0], 1'b1);
    tick();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hAA; wr_pred_idx = 5'd10; wr_pred_res = 1'b0;
    #2 check("squash_no_bypass", rd_data[31:0], 32'h0);
    tick();
    clr_wr();
    #2 check("squash_r7", rd_data[31:0], 32'h0);
    check("squash_busy_clr", rd_busy[0], 1'b0);
    tick();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hAA; wr_pred_idx = 5'd10; wr_pred_res = 1'b1;
    tick();
    clr_wr();
    #2 check("pred_true_r7", rd_data[31:0], 32'hAA);

    // issue r3 at t, write-back plus re-issue at t+3
    tick();
    rd_addr = {5'd0, 5'd0, 5'd3};
    iss_en = 1'b1; iss_addr = 5'd3;
    tick();
    clr_wr();
    #2 check("busy_t1", rd_busy[0], 1'b1);
    tick();
    #2 check("busy_t2", rd_busy[0], 1'b1);
    tick();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd9; iss_en = 1'b1; iss_addr = 5'd3;
    #2 check("busy_t3", rd_busy[0], 1'b1);
    tick();
    clr_wr();
    #2 check("busy_set_wins", rd_busy[0], 1'b1);
    check("r3_val", rd_data[31:0], 32'd9);

    // stall holds PC but not write-back
    tick();
    pc_next = 32'h20;
    tick();
    stall = 1'b1; pc_next = 32'h40;
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h55;
    tick();
    clr_wr();
    rd_addr = {5'd0, 5'd0, 5'd4};
    #2 check("stall_pc", pc, 32'h20);
    check("stall_r4", rd_data[31:0], 32'h55);
    stall = 1'b0;
    tick();
    rd_addr = {5'd0, 5'd0, 5'd30};
    #2 check("pc_after", pc, 32'h40);
    check("pc_mirror", rd_data[31:0], 32'h40);

    // writes to r0 and the PC mirror are dropped
    tick();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF;
    tick();
    wr_addr = 5'd30;
    tick();
    clr_wr();
    rd_addr = {5'd0, 5'd30, 5'd0};
    #2 check("r0_ignored", rd_data[31:0], 32'h0);
    check("r30_ignored", rd_data[63:32], 32'h40);

    // reset during init restarts the full sequence
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    check("mid_init_ready", ready, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd_addr = {5'd0, 5'd0, 5'd3};
    wait_ready(n_cyc);
    check("reinit_cycles", n_cyc, 32);
    #2 check("reinit_busy", rd_busy[0], 1'b0);
    check("reinit_pc", pc, 32'h0);
    check("reinit_r3", rd_data[31:0], 32'h0);

    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
